// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Largest value representable in the given number of decimal digits.
    function automatic logic [31:0] max_dec(input int unsigned digits);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 32'd10;
        end
        return r - 32'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: add 3 to any digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// The output register updates only on completion, so no partial result is visible.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               last_step;
    logic               in_range_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    assign last_step    = (cnt_q == CNT_W'(1));
    assign in_range_ovf = (32'(bin) > max_dec(DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = CONVERT;
            CONVERT: if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = in_range_ovf;
                end
            end
            CONVERT: begin
                scratch_d = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                // A carry out of the top digit only arises for out-of-range inputs.
                ovf_pend_d = ovf_pend_q | adj[SCR_W-1];
                if (last_step) begin
                    bcd_d  = ovf_pend_q ? {DIGITS{BCD_NINE}} : scratch_d;
                    ovf_d  = ovf_pend_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q == CONVERT);
        done     = done_q;
        bcd      = bcd_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with an arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(
        .BIN_W  (14),
        .DIGITS (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Waits (bounded) for done; n counts falling edges, bz counts busy cycles seen.
    task automatic wait_done(input logic [15:0] hold, output int n, output int bz,
                             output bit got, output bit held);
        n = 0; bz = 0; got = 1'b0; held = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bz++;
            if (done) got = 1'b1;
            else if (bcd !== hold) held = 1'b0;
        end
    endtask

    task automatic run(input logic [13:0] v, input logic [13:0] nb, input bit keep,
                       output int n, output int bz, output bit got, output bit held);
        logic [15:0] hold;
        int bz0;
        hold  = bcd;
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        if (!keep) start = 1'b0;
        bin = nb;
        bz0 = busy ? 1 : 0;
        if (done) held = 1'b0;
        wait_done(hold, n, bz, got, held);
        n  = n + 1;
        bz = bz + bz0;
    endtask

    initial begin
        int n, bz, dcnt;
        bit got, held;
        int vals[$];

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Reset and start together: reset must win.
        start = 1'b1;
        bin   = 14'd123;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run(14'd0, 14'd0, 1'b0, n, bz, got, held);
        check("t1_got", 32'(got), 32'd1);
        check("t1_latency", 32'(n), 32'd15);
        check("t1_busy_cycles", 32'(bz), 32'd14);
        check("t1_bcd", 32'(bcd), 32'h0000);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done), 32'd0);

        run(14'd9999, 14'd9999, 1'b0, n, bz, got, held);
        check("t2_bcd_9999", 32'(bcd), 32'h9999);
        check("t2_ovf_9999", 32'(overflow), 32'd0);
        run(14'd1234, 14'd1234, 1'b0, n, bz, got, held);
        check("t2_hold", 32'(held), 32'd1);
        check("t2_bcd_1234", 32'(bcd), 32'h1234);

        // start held high with bin changing during busy.
        run(14'd1234, 14'd5678, 1'b1, n, bz, got, held);
        check("t3_first_latency", 32'(n), 32'd15);
        check("t3_first_bcd", 32'(bcd), 32'h1234);
        wait_done(bcd, n, bz, got, held);
        start = 1'b0;
        check("t3_b2b_spacing", 32'(n), 32'd15);
        check("t3_second_bcd", 32'(bcd), 32'h5678);
        @(negedge clk);

        run(14'd10000, 14'd10000, 1'b0, n, bz, got, held);
        check("t4_ovf_10000", 32'(overflow), 32'd1);
        check("t4_bcd_10000", 32'(bcd), 32'h9999);
        run(14'd16383, 14'd16383, 1'b0, n, bz, got, held);
        check("t4_ovf_16383", 32'(overflow), 32'd1);
        check("t4_bcd_16383", 32'(bcd), 32'h9999);
        run(14'd42, 14'd42, 1'b0, n, bz, got, held);
        check("t4_ovf_42", 32'(overflow), 32'd0);
        check("t4_bcd_42", 32'(bcd), 32'h0042);

        // Abort a conversion of 507 mid-way.
        start = 1'b1;
        bin   = 14'd507;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_bcd", 32'(bcd), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        dcnt  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t5_no_done", 32'(dcnt), 32'd0);
        run(14'd507, 14'd507, 1'b0, n, bz, got, held);
        check("t5_latency", 32'(n), 32'd15);
        check("t5_bcd_507", 32'(bcd), 32'h0507);
        @(negedge clk);

        // Back-to-back sweep over low range, saturation boundary and top of range.
        for (int v = 0; v < 2048; v++) vals.push_back(v);
        for (int v = 9990; v <= 10010; v++) vals.push_back(v);
        for (int v = 16370; v <= 16383; v++) vals.push_back(v);
        start = 1'b1;
        bin   = 14'(vals[0]);
        for (int i = 0; i < vals.size(); i++) begin
            wait_done(bcd, n, bz, got, held);
            if (i + 1 < vals.size()) bin = 14'(vals[i+1]);
            else start = 1'b0;
            if (!got) begin
                check("t6_timeout", 32'(got), 32'd1);
            end else begin
                check($sformatf("t6_spacing_%0d", vals[i]), 32'(n), 32'd15);
                check($sformatf("t6_bcd_%0d", vals[i]), 32'(bcd), 32'(ref_bcd(vals[i])));
                check($sformatf("t6_ovf_%0d", vals[i]), 32'(overflow),
                      (vals[i] > 9999) ? 32'd1 : 32'd0);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
